// File: rtl/y_seq_mult.sv
// ---------------------------------------------------------------------------
// y_seq_mult -- multi-cycle unsigned shift-add multiplier.
//
// Performs one conditional add-and-shift per clock into a double-width
// accumulator and returns a 2*WIDTH-bit product. It consumes operands from the
// datapath adder stage and reports back to the controller with start/busy/done.
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   undefined : every operation takes exactly WIDTH steps.
//   defined   : RUN also ends on the step that leaves no set multiplier bits,
//               so the step count is (index of highest set bit of b)+1, or 1 if
//               b==0. The product is identical in both builds.
//
// Ports
//   clk       in   1         rising-edge clock
//   resetn    in   1         asynchronous active-low reset
//   start     in   1         operation request (sampled in IDLE or DONE only)
//   a         in   WIDTH     multiplicand, captured when start is accepted
//   b         in   WIDTH     multiplier, captured when start is accepted
//   busy      out  1         high while an operation is running
//   done      out  1         one-cycle pulse, product valid
//   product   out  2*WIDTH   last completed result, held until next completion
//   dbg_state out  2         current FSM state, for checkers
//
// Handshake: start is accepted on any rising edge where busy is low (IDLE or
// DONE); a/b are captured on that same edge. While busy is high, start is
// ignored. done is high for exactly one cycle after the completion edge, and
// product is updated only on that edge. Holding start high through DONE
// launches the next operation back-to-back without an IDLE cycle.
// ---------------------------------------------------------------------------
module y_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Count value seen during the final step of a full-length operation.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]           state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplr;
  logic [CW-1:0]        cnt;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   next_acc;
  logic                 last_step;

  // Accumulator value after the current RUN step; also the final product
  // when this is the last step.
  always_comb begin
    addend   = mplr[0] ? mcand : '0;
    next_acc = acc + addend;
  end

`ifdef MULT_EARLY_EXIT_EN
  // Stop once the shifted multiplier would have no bits left to add.
  always_comb begin
    last_step = (cnt == LAST_CNT) || (mplr[WIDTH-1:1] == '0);
  end
`else
  always_comb begin
    last_step = (cnt == LAST_CNT);
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= next_acc;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            product <= next_acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_y_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_y_seq_mult -- self-checking bench for y_seq_mult (WIDTH=32).
// The driver pushes the expected product and the expected done cycle when an
// operation is accepted; a negedge monitor pops and compares on every done.
// Build with +define+MULT_EARLY_EXIT_EN on both files to test early exit.
// ---------------------------------------------------------------------------
module tb_y_seq_mult;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  y_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
  int             checks = 0;
  int             passes = 0;
  int             accepted = 0;
  int             dones = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference step count derived directly from the operand value.
  function automatic int ref_n(input logic [W-1:0] bv);
    int n;
`ifdef MULT_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        dones++;
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          chk("product", product, exp_q[0]);
          chk("latency", 64'(cyc), 64'(cyc_q[0]));
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end else if (cyc_q.size() > 0) begin
        if (cyc >= cyc_q[0]) begin
          chk("done_missing", 64'(cyc), 64'(cyc_q[0] - 1));
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end else begin
          chk("busy_in_run", {63'b0, busy}, 64'd1);
        end
      end else begin
        chk("busy_idle", {63'b0, busy}, 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Waits for a negedge with busy low, presents operands, and records the
  // expectation right after the accepting edge. start is left as given by keep.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep);
    logic [2*W-1:0] ea, eb;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("issue_timeout", 64'(guard), 64'd0);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    ea = {{W{1'b0}}, av};
    eb = {{W{1'b0}}, bv};
    exp_q.push_back(ea * eb);
    cyc_q.push_back(cyc + ref_n(bv));
    accepted++;
    if (!keep) start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    bit           hold;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // directed cases
    issue(32'd3, 32'd5, 1'b0);
    drain();
    chk("hold_after_done", product, 64'h0000_0000_0000_000F);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();

    // second start during RUN is ignored
    issue(32'd7, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    drain();

    // asynchronous reset mid-run discards the operation
    issue(32'h0000_FFFF, 32'h8000_0001, 1'b0);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_done", {63'b0, done}, 64'd0);
    chk("async_rst_product", product, 64'd0);
    accepted -= exp_q.size();
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    issue(32'd4, 32'd6, 1'b0);
    drain();

    // b == 0
    issue(32'h1234_5678, 32'd0, 1'b0);
    drain();

    // back-to-back: start held through DONE
    issue(32'd6, 32'd7, 1'b1);
    a = 32'd10; b = 32'd10;
    issue(32'd10, 32'd10, 1'b0);
    drain();

    // randomized operations, some launched back-to-back
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      hold = ($urandom_range(0, 2) == 0);
      issue(ra, rb, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start = 1'b0;
    drain();

    chk("done_count", 64'(dones), 64'(accepted));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // absolute safety bound
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
